dot_product_acc: RTL and testbench

//  Streaming fixed-point dot product w.x feeding the sigmoid LUT stage.
//  - Accepts numLanes (w,x) pairs per beat over vec_len beats.
//  - Accumulates full-precision products.
//  - Rescales by fracLen, saturates to dataLen and presents one result word
//    (same Q format as sigmoid input) on a valid/ready port.

---
 rtl/dot_product_acc.sv | 91 +++++++++
 tb/tb_dot_product_acc.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dot_product_acc.sv
// dot_product_acc: streaming signed fixed-point dot product with rescale and saturation.
// Optional DOT_ROUND_EN adds round-half-up before the rescale shift.
module dot_product_acc #(
    parameter int dataLen  = 16,
    parameter int fracLen  = 8,
    parameter int numLanes = 4,
    parameter int accLen   = 48,
    parameter int cntLen   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [cntLen-1:0]            vec_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [numLanes*dataLen-1:0]  w_in,
    input  logic [numLanes*dataLen-1:0]  x_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [dataLen-1:0]           out_data,
    output logic                         busy
);
    typedef enum logic [2:0] {IDLE, ACC, DRAIN1, DRAIN2, OUT} state_t;
    localparam logic signed [accLen-1:0] s_max = {{(accLen-dataLen+1){1'b0}}, {(dataLen-1){1'b1}}};
    localparam logic signed [accLen-1:0] s_min = {{(accLen-dataLen+1){1'b1}}, {(dataLen-1){1'b0}}};
    state_t state, next;
    logic [cntLen-1:0] rem;
    logic signed [accLen-1:0] acc, lane_sum, sh;
    logic signed [2*dataLen-1:0] prod [numLanes];
    logic pv, hs;
    logic [dataLen-1:0] sat;
    assign hs = in_valid & in_ready;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        in_ready = 1'b0;
        out_valid = 1'b0;
        busy = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next = (vec_len != '0) ? ACC : DRAIN1;
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && rem == cntLen'(1)) next = DRAIN1;
            end
            DRAIN1: next = DRAIN2;
            DRAIN2: next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < numLanes; i++)
            lane_sum = lane_sum + {{(accLen-2*dataLen){prod[i][2*dataLen-1]}}, prod[i]};
    end
`ifdef DOT_ROUND_EN
    localparam logic signed [accLen-1:0] half = {{(accLen-fracLen){1'b0}}, 1'b1, {(fracLen-1){1'b0}}};
    assign sh = (acc + half) >>> fracLen;
`else
    assign sh = acc >>> fracLen;
`endif
    assign sat = (sh > s_max) ? s_max[dataLen-1:0] : (sh < s_min) ? s_min[dataLen-1:0] : sh[dataLen-1:0];
    // pv marks a product set captured last cycle that still has to reach acc
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rem <= '0;
            acc <= '0;
            pv <= 1'b0;
            out_data <= '0;
            for (int i = 0; i < numLanes; i++) prod[i] <= '0;
        end else begin
            if (state == IDLE && start) begin
                rem <= vec_len;
                acc <= '0;
            end else if (pv) acc <= acc + lane_sum;
            if (hs) rem <= rem - cntLen'(1);
            pv <= hs;
            if (hs)
                for (int i = 0; i < numLanes; i++)
                    prod[i] <= $signed(w_in[i*dataLen +: dataLen]) * $signed(x_in[i*dataLen +: dataLen]);
            if (state == DRAIN2) out_data <= sat;
        end
endmodule

// File: tb/tb_dot_product_acc.sv
// tb_dot_product_acc: directed vector table plus stall, restart and reset sequences.
module tb_dot_product_acc;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] vec_len = '0;
    logic [63:0] w_in = '0, x_in = '0;
    logic in_ready, out_valid, busy;
    logic [15:0] out_data;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    dot_product_acc dut (.clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
        .in_valid(in_valid), .in_ready(in_ready), .w_in(w_in), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));
    typedef struct {
        int n;
        logic [63:0] w;
        logic [63:0] x;
        int exp;
        string name;
    } vec_t;
    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction
    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask
    task automatic finish_result(input string name, input int exp, input int lat0);
        int lat = lat0;
        int rdy = 0;
        while (!out_valid && lat < 20) begin
            rdy |= int'(in_ready);
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_in_ready_low"}, rdy | int'(in_ready), 0);
        check({name, "_data"}, int'($signed(out_data)), exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_done"}, int'({out_valid, busy}), 0);
    endtask
    task automatic run_dot(input int n, input logic [63:0] w, input logic [63:0] x,
                           input int exp, input string name);
        start = 1'b1;
        vec_len = 16'(n);
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < n; b++) begin
            in_valid = 1'b1;
            w_in = w;
            x_in = x;
            if (!in_ready) check({name, "_ready"}, 0, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        finish_result(name, exp, 1);
    endtask
    int rnd_m1;
    int rnd_q;
    logic [15:0] held;
    int stable_bad;
    vec_t tbl [6];
    initial begin
`ifdef DOT_ROUND_EN
        rnd_m1 = 0;
        rnd_q = 1;
`else
        rnd_m1 = -1;
        rnd_q = 0;
`endif
        tbl[0] = '{1, pk(256, 256, 256, 256), pk(256, 512, -256, 128), 640, "t1_2p5"};
        tbl[1] = '{4, pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767), 32767, "t2_sat_max"};
        tbl[2] = '{4, pk(32767, 32767, 32767, 32767), pk(-32768, -32768, -32768, -32768), -32768, "t2_sat_min"};
        tbl[3] = '{1, pk(1, 0, 0, 0), pk(128, 0, 0, 0), rnd_q, "t6_half"};
        tbl[4] = '{2, pk(-256, 0, 0, 0), pk(384, 0, 0, 0), -768, "neg_sum"};
        tbl[5] = '{1, pk(-1, 0, 0, 0), pk(1, 0, 0, 0), rnd_m1, "neg_floor"};
        #12;
        check("rst_outputs", int'({in_ready, out_valid, busy}), 0);
        check("rst_data", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        foreach (tbl[i]) run_dot(tbl[i].n, tbl[i].w, tbl[i].x, tbl[i].exp, tbl[i].name);
        // zero-length vector goes straight to drain
        run_dot(0, pk(99, 99, 99, 99), pk(99, 99, 99, 99), 0, "t3_empty");
        // gapped input with stray start pulses, then a stalled consumer
        start = 1'b1;
        vec_len = 16'd3;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            in_valid = (b % 2 == 0);
            start = (b % 2 == 1);
            vec_len = 16'd7;
            w_in = pk(256, 0, 0, 0);
            x_in = pk(256 * (b / 2 + 1), 0, 0, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("t4_ready_after", int'(in_ready), 0);
        for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
        check("t4_valid", int'(out_valid), 1);
        held = out_data;
        stable_bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_data !== held || !out_valid || in_ready) stable_bad++;
        end
        check("t4_stall_stable", stable_bad, 0);
        check("t4_data", int'($signed(held)), 1536);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        stable_bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid || busy) stable_bad++;
            @(negedge clk);
        end
        check("t4_single_result", stable_bad, 0);
        // reset in the middle of accumulation discards the partial sum
        start = 1'b1;
        vec_len = 16'd4;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        w_in = pk(1000, 1000, 1000, 1000);
        x_in = pk(1000, 1000, 1000, 1000);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_flags", int'({in_ready, out_valid, busy}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_dot(1, pk(256, 0, 0, 0), pk(256, 0, 0, 0), 256, "t5_no_residue");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
